// File: rtl/pipe_flow_ctrl.sv
// Pipeline flow controller: prioritised enable/bubble/flush generation for the
// PC and pipeline registers, MDU busy sequencing and a stall-cycle counter.
module pipe_flow_ctrl #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10,
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned PERF_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_data,
    input  logic              D_is_md,
    input  logic              E_md_start,
    input  logic              E_md_div,
    input  logic              exc_req,
    input  logic              D_eret,
    output logic              pc_en,
    output logic              fd_en,
    output logic              fd_flush,
    output logic              de_bubble,
    output logic              de_req,
    output logic              de_exlclr,
    output logic [1:0]        pc_sel,
    output logic              md_busy,
    output logic [CNT_W-1:0]  md_cnt,
    output logic [PERF_W-1:0] stall_cnt
);

    localparam logic [1:0] SEL_SEQ = 2'b00;
    localparam logic [1:0] SEL_EXC = 2'b01;
    localparam logic [1:0] SEL_EPC = 2'b10;

    logic              md_busy_q, md_busy_d;
    logic [CNT_W-1:0]  md_cnt_q, md_cnt_d;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
    logic              md_stall;
    logic              stall;
    logic              md_start;

    assign md_stall = D_is_md & (md_busy_q | E_md_start);
    assign stall    = stall_data | md_stall;
    // A start coinciding with an exception belongs to the flushed E instruction.
    assign md_start = E_md_start & ~exc_req;

    always_comb begin
        pc_en     = 1'b1;
        fd_en     = 1'b1;
        fd_flush  = 1'b0;
        de_bubble = 1'b0;
        de_req    = 1'b0;
        de_exlclr = 1'b0;
        pc_sel    = SEL_SEQ;
        if (!reset) begin
            if (exc_req) begin
                de_req   = 1'b1;
                fd_flush = 1'b1;
                pc_sel   = SEL_EXC;
            end else if (stall) begin
                pc_en     = 1'b0;
                fd_en     = 1'b0;
                de_bubble = 1'b1;
            end else if (D_eret) begin
                fd_flush = 1'b1;
                pc_sel   = SEL_EPC;
            end
        end
    end

    always_comb begin
        md_busy_d = md_busy_q;
        md_cnt_d  = md_cnt_q;
        if (md_start) begin
            md_cnt_d  = E_md_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
            md_busy_d = 1'b1;
        end else if (md_cnt_q > CNT_W'(1)) begin
            md_cnt_d = md_cnt_q - CNT_W'(1);
        end else if (md_cnt_q == CNT_W'(1)) begin
            md_cnt_d  = '0;
            md_busy_d = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !exc_req && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            md_busy_q   <= 1'b0;
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            md_busy_q   <= md_busy_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign md_busy   = md_busy_q;
    assign md_cnt    = md_cnt_q;
    assign stall_cnt = stall_cnt_q;

endmodule
